// File: rtl/regmask_encoder_32_if.sv
// -----------------------------------------------------------------------------
// regmask_encoder_32_if
// Bundles the request-load and index-stream signals of regmask_encoder_32.
//   load_en / load_mask : producer side, merges a multi-hot request mask
//   out_valid / out_reg / out_ready : index stream, one index per handshake
//   pending / idle      : status of the buffered requests
// The encoder connects through the slave modport; the requesting logic (or a
// testbench) uses the master modport.
// -----------------------------------------------------------------------------
interface regmask_encoder_32_if #(
   parameter int NREGS = 32,
   parameter int IDX_W = 5
);
   logic             load_en;
   logic [NREGS-1:0] load_mask;
   logic             out_valid;
   logic [IDX_W-1:0] out_reg;
   logic             out_ready;
   logic [NREGS-1:0] pending;
   logic             idle;

   modport master (
      output load_en, load_mask, out_ready,
      input  out_valid, out_reg, pending, idle
   );

   modport slave (
      input  load_en, load_mask, out_ready,
      output out_valid, out_reg, pending, idle
   );
endinterface

// File: rtl/regmask_encoder_32.sv
// -----------------------------------------------------------------------------
// regmask_encoder_32
// Collects multi-hot register write-request masks into a pending set and
// serialises them into a stream of register indices, one per handshake.
//
// Ports
//   clock    : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : regmask_encoder_32_if.slave
//              load_en/load_mask in, out_valid/out_reg out, out_ready in,
//              pending out (requests not yet in the output slot),
//              idle out (pending empty and output slot empty)
//
// Configuration macro: ROUND_ROBIN_EN
//   undefined : lowest pending index is granted first
//   defined   : a rotating pointer (granted index + 1) selects the first
//               pending index at or above it, wrapping to index 0
// -----------------------------------------------------------------------------
module regmask_encoder_32 #(
   parameter int NREGS   = 32,
   parameter int IDX_W   = 5,
   parameter int MASK_R0 = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   regmask_encoder_32_if.slave  bus
);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [NREGS-1:0] pending_q, pending_d;
   logic [IDX_W-1:0] out_reg_q, out_reg_d;

   logic [NREGS-1:0] mask_eff_s;
   logic [NREGS-1:0] grant_onehot_s;
   logic [IDX_W-1:0] sel_idx_s;
   logic             sel_found_s;
   logic             move_s;

`ifdef ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_q, rr_d;
   logic [IDX_W-1:0] rr_cand_s;
`endif

   // Incoming mask with r0 optionally stripped (r0 hardwired to zero).
   always_comb begin
      if (MASK_R0 != 0) begin
         mask_eff_s = {bus.load_mask[NREGS-1:1], 1'b0};
      end else begin
         mask_eff_s = bus.load_mask;
      end
   end

   // Pick the next index to move from the pending set into the output slot.
   always_comb begin
      sel_idx_s   = {IDX_W{1'b0}};
      sel_found_s = 1'b0;
`ifdef ROUND_ROBIN_EN
      rr_cand_s   = {IDX_W{1'b0}};
      // Walk upward from the pointer; the index add wraps modulo NREGS.
      for (int i = 0; i < NREGS; i++) begin
         rr_cand_s = rr_q + IDX_W'(i);
         if (!sel_found_s && pending_q[rr_cand_s]) begin
            sel_idx_s   = rr_cand_s;
            sel_found_s = 1'b1;
         end else begin
            sel_found_s = sel_found_s;
         end
      end
`else
      // Scan downward so the last hit, i.e. the lowest set bit, wins.
      for (int i = NREGS - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_idx_s   = IDX_W'(i);
            sel_found_s = 1'b1;
         end else begin
            sel_found_s = sel_found_s;
         end
      end
`endif
   end

   // Slot FSM next state, slot contents and pending-set update.
   always_comb begin
      state_d   = state_q;
      out_reg_d = out_reg_q;
      move_s    = 1'b0;
      case (state_q)
         S_EMPTY: begin
            if (sel_found_s) begin
               state_d   = S_FULL;
               out_reg_d = sel_idx_s;
               move_s    = 1'b1;
            end else begin
               state_d   = S_EMPTY;
            end
         end
         S_FULL: begin
            if (bus.out_ready) begin
               if (sel_found_s) begin
                  out_reg_d = sel_idx_s;
                  move_s    = 1'b1;
               end else begin
                  state_d   = S_EMPTY;
               end
            end else begin
               // Consumer stalled: slot contents are frozen.
               state_d = S_FULL;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase

      if (move_s) begin
         grant_onehot_s = {{(NREGS-1){1'b0}}, 1'b1} << sel_idx_s;
      end else begin
         grant_onehot_s = {NREGS{1'b0}};
      end

      // Clear before OR-ing in the load so a same-edge re-request survives.
      if (bus.load_en) begin
         pending_d = (pending_q & ~grant_onehot_s) | mask_eff_s;
      end else begin
         pending_d = pending_q & ~grant_onehot_s;
      end

`ifdef ROUND_ROBIN_EN
      if (move_s) begin
         rr_d = sel_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
      end else begin
         rr_d = rr_q;
      end
`endif
   end

   // State register: slot FSM, slot index, pending set (and rr pointer).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_EMPTY;
         out_reg_q <= {IDX_W{1'b0}};
         pending_q <= {NREGS{1'b0}};
`ifdef ROUND_ROBIN_EN
         rr_q      <= {IDX_W{1'b0}};
`endif
      end else begin
         state_q   <= state_d;
         out_reg_q <= out_reg_d;
         pending_q <= pending_d;
`ifdef ROUND_ROBIN_EN
         rr_q      <= rr_d;
`endif
      end
   end

   assign bus.out_valid = (state_q == S_FULL);
   assign bus.out_reg   = out_reg_q;
   assign bus.pending   = pending_q;
   // Derived from registered state only; no input feeds idle.
   assign bus.idle      = (pending_q == {NREGS{1'b0}}) && (state_q == S_EMPTY);

endmodule

// File: tb/tb_regmask_encoder_32.sv
// -----------------------------------------------------------------------------
// tb_regmask_encoder_32
// Scoreboard bench: a behavioural model (set arithmetic on the pending mask)
// pushes each granted index into exp_q; a negedge monitor pops it on every
// DUT handshake and also compares pending/out_valid/idle every cycle.
// A second instance with MASK_R0=1 covers the r0-discard behaviour.
// -----------------------------------------------------------------------------
module tb_regmask_encoder_32;
   localparam int NREGS = 32;
   localparam int IDX_W = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regmask_encoder_32_if #(.NREGS(NREGS), .IDX_W(IDX_W)) bus  ();
   regmask_encoder_32_if #(.NREGS(NREGS), .IDX_W(IDX_W)) bus1 ();

   regmask_encoder_32 #(.NREGS(NREGS), .IDX_W(IDX_W), .MASK_R0(0)) u_dut (
      .clock(clk), .reset_n(rst_n), .bus(bus));
   regmask_encoder_32 #(.NREGS(NREGS), .IDX_W(IDX_W), .MASK_R0(1)) u_dut_r0 (
      .clock(clk), .reset_n(rst_n), .bus(bus1));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_pend;
   logic        m_valid;
   int          m_slot;
   int          m_ptr;
   int          exp_q[$];
   int          log_q[$];

   function automatic int lowest(logic [31:0] v);
      logic [31:0] iso;
      iso = v & (~v + 32'd1);
      return $clog2(iso);
   endfunction

   function automatic int pick(logic [31:0] p, int ptr);
`ifdef ROUND_ROBIN_EN
      logic [31:0] hi;
      hi = p & ~((32'd1 << ptr) - 32'd1);
      if (hi != 32'd0) return lowest(hi);
      return lowest(p);
`else
      if (ptr < 0) return 0;
      return lowest(p);
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      logic [31:0] add;
      bit          take;
      int          g;
      if (!rst_n) begin
         m_pend  = 32'd0;
         m_valid = 1'b0;
         m_slot  = 0;
         m_ptr   = 0;
         exp_q.delete();
      end else begin
         add  = bus.load_en ? bus.load_mask : 32'd0;
         take = (m_pend != 32'd0) && (!m_valid || bus.out_ready);
         if (m_valid && bus.out_ready && !take) m_valid = 1'b0;
         if (take) begin
            g         = pick(m_pend, m_ptr);
            m_pend[g] = 1'b0;
            m_slot    = g;
            m_valid   = 1'b1;
            m_ptr     = (g + 1) % NREGS;
            exp_q.push_back(g);
         end
         m_pend = m_pend | add;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         check("pending",   bus.pending, m_pend);
         check("out_valid", 32'(bus.out_valid), 32'(m_valid));
         check("idle",      32'(bus.idle), 32'((m_pend == 32'd0) && !m_valid));
         if (bus.out_valid && m_valid) check("out_reg", 32'(bus.out_reg), 32'(m_slot));
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL stream_idx: got %0d expected none", bus.out_reg);
            end else begin
               check("stream_idx", 32'(bus.out_reg), 32'(exp_q.pop_front()));
            end
            log_q.push_back(int'(bus.out_reg));
         end
      end
   end

   int r0_cnt  = 0;
   int r0_last = -1;
   always @(negedge clk) begin
      if (rst_n && bus1.out_valid && bus1.out_ready) begin
         r0_cnt++;
         r0_last = int'(bus1.out_reg);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(logic en, logic [31:0] mask, logic rdy);
      @(posedge clk);
      #2;
      bus.load_en   = en;
      bus.load_mask = mask;
      bus.out_ready = rdy;
   endtask

   task automatic drain(string name);
      bit done;
      done = 1'b0;
      drive(1'b0, 32'd0, 1'b1);
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (bus.idle) done = 1'b1;
      end
      check({name, "_drain_idle"}, 32'(bus.idle), 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n         = 1'b0;
      bus.load_en   = 1'b0;
      bus.load_mask = 32'd0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic check_log(string name, int n, int e0, int e1, int e2);
      int e[3];
      e = '{e0, e1, e2};
      check({name, "_count"}, 32'(log_q.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < log_q.size()) check({name, "_order"}, 32'(log_q[i]), 32'(e[i]));
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      bus.load_en    = 1'b0;
      bus.load_mask  = 32'd0;
      bus.out_ready  = 1'b0;
      bus1.load_en   = 1'b0;
      bus1.load_mask = 32'd0;
      bus1.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_idle", 32'(bus.idle), 32'd1);
      check("rst_out_reg", 32'(bus.out_reg), 32'd0);

      // 1: reset mid-stream with pending = F0 and a full slot
      drive(1'b1, 32'h2, 1'b0);
      drive(1'b1, 32'hF0, 1'b0);
      drive(1'b0, 32'd0, 1'b0);
      @(negedge clk);
      check("t1_pend_before", bus.pending, 32'hF0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_pend_rst", bus.pending, 32'd0);
      check("t1_valid_rst", 32'(bus.out_valid), 32'd0);
      check("t1_idle_rst", 32'(bus.idle), 32'd1);
      do_reset();

      // 2: multi-hot mask drains in index order
      log_q.delete();
      drive(1'b1, 32'h0000_8112, 1'b1);
      drain("t2");
      check("t2_count", 32'(log_q.size()), 32'd4);
      if (log_q.size() == 4) begin
         check("t2_i0", 32'(log_q[0]), 32'd1);
         check("t2_i1", 32'(log_q[1]), 32'd4);
         check("t2_i2", 32'(log_q[2]), 32'd8);
         check("t2_i3", 32'(log_q[3]), 32'd15);
      end

      // 3: r0 is a normal request with MASK_R0=0, discarded with MASK_R0=1
      do_reset();
      log_q.delete();
      drive(1'b1, 32'h1, 1'b1);
      drain("t3");
      check_log("t3_r0_kept", 1, 0, 0, 0);
      @(posedge clk);
      #2;
      r0_cnt         = 0;
      bus1.load_en   = 1'b1;
      bus1.load_mask = 32'h1;
      bus1.out_ready = 1'b1;
      @(posedge clk);
      #2;
      bus1.load_en = 1'b0;
      repeat (5) @(negedge clk);
      check("t3_r0_none", 32'(r0_cnt), 32'd0);
      check("t3_r0_pend", bus1.pending, 32'd0);
      check("t3_r0_idle", 32'(bus1.idle), 32'd1);
      @(posedge clk);
      #2;
      bus1.load_en   = 1'b1;
      bus1.load_mask = 32'h3;
      @(posedge clk);
      #2;
      bus1.load_en = 1'b0;
      repeat (6) @(negedge clk);
      check("t3_r0_one", 32'(r0_cnt), 32'd1);
      check("t3_r0_idx", 32'(r0_last), 32'd1);

      // 4: backpressure holds the slot
      do_reset();
      log_q.delete();
      drive(1'b1, 32'h6, 1'b0);
      drive(1'b0, 32'd0, 1'b0);
      @(posedge clk);
      repeat (5) begin
         @(negedge clk);
         check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
         check("t4_hold_reg", 32'(bus.out_reg), 32'd1);
         check("t4_hold_pend", bus.pending, 32'h4);
      end
      drain("t4");
      check_log("t4", 2, 1, 2, 0);

      // 5: re-request of the index currently leaving the slot
      do_reset();
      log_q.delete();
      drive(1'b1, 32'h8, 1'b0);
      drive(1'b0, 32'd0, 1'b0);
      @(posedge clk);
      drive(1'b1, 32'h88, 1'b1);
      drain("t5");
`ifdef ROUND_ROBIN_EN
      check_log("t5", 3, 3, 7, 3);
`else
      check_log("t5", 3, 3, 3, 7);
`endif

      // 6: wrap order, pointer parked at 31 by granting 30 first
      do_reset();
      drive(1'b1, 32'h4000_0000, 1'b1);
      drain("t6a");
      log_q.delete();
      drive(1'b1, 32'h8000_0003, 1'b1);
      drain("t6");
`ifdef ROUND_ROBIN_EN
      check_log("t6", 3, 31, 0, 1);
`else
      check_log("t6", 3, 0, 1, 31);
`endif

      // random traffic against the model
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         drive(($urandom % 4) == 0,
               $urandom & $urandom & $urandom,
               ($urandom % 4) != 0);
      end
      drain("rand");
      check("rand_exp_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
